dmem_hs: RTL and testbench
==========================

Name: dmem_hs

Overview:
- Parametrised data memory for the RISC-V core: byte-addressed, word-organised, with correct byte-lane placement for SB/SH/LB/LH/LBU/LHU.
- Valid/ready request and response handshakes with a configurable read latency, so the load/store unit can stall on memory.
- Sits between the core's MEM stage and the backing storage.
- Next-generation replacement for the fixed-size, lane-0-only, negedge-write data memory.

Parameters:
- DEPTH, 32768, number of 32-bit words; power of two, ≥ 4.
- ADDR_W, $clog2(DEPTH)+2, byte-address width; derived, not overridden.
- LATENCY, 1, cycles from request accept to response valid; range 1..15.
- INIT_FILE, "", hex image loaded with $readmemh when non-empty; otherwise contents are X.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_type  in  3  funct3: loads LB=0, LH=1, LW=2, LBU=4, LHU=5; stores SB=0, SH=1, SW=2.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  access faulted (misaligned; see Optional Feature).

Behaviour:
- Storage and addressing:
  - Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
  - Storage has no reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE) && rst_n; purely combinational from state.
  - Accept = req_valid && req_ready at a rising edge.
  - IDLE -> RESP on accept when LATENCY = 1.
  - IDLE -> WAIT on accept when LATENCY > 1; a 4-bit counter is loaded with LATENCY-2.
  - WAIT: counter decrements each cycle; -> RESP when counter = 0.
  - RESP: resp_valid = 1; -> IDLE on resp_ready.
  - resp_rdata and resp_err stay stable while resp_valid && !resp_ready.
- Timing:
  - resp_valid rises exactly LATENCY cycles after the accept edge.
  - One outstanding transaction; a new accept is only possible the cycle after the response handshake.
- Store commit:
  - Store commits on the accept edge; byte enables are derived from req_type and lane.
  - SB: wdata[7:0] goes to lane byte.
  - SH: wdata[15:0] goes to bytes lane..lane+1, with lane ∈ {0,2}.
  - SW: full word, lane 0.
  - Untouched bytes are preserved.
- Load capture:
  - Load data is sampled from storage at the accept edge, extracted from the lane, extended per type, and held in a response register.
  - Load reads post-accept contents, consistent with program order since one transaction is outstanding.
- Undefined req_type (3, 6, 7; stores ≥ 3):
  - Treated as LW/SW.
- Reset:
  - rst_n = 0 at an edge: state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - An in-flight response is discarded; a store already committed stays committed.
  - req_ready = 0 while rst_n = 0.
- Boundaries:
  - Highest address DEPTH*4-4 is valid.
  - Ignore req_* when not ready.
  - resp_ready while not valid has no effect.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access sets resp_err = 1 and resp_rdata = 0, with no storage write. Normal latency still applies.
  - Misaligned means an H type with lane[0] = 1, or a W type with lane ≠ 0.
- Undefined: a misaligned access is force-aligned (H: lane[0] ignored; W: lane ignored), and resp_err is tied to 0.

Decomposition:
- Package dmem_pkg:
  - load/store funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - the FSM state enum;
  - function misaligned(type, lane).
- Sub-module dmem_lane (combinational):
  - takes type, lane, and wdata;
  - produces byte enables [3:0], the lane-shifted write word, and the extracted/extended load value from the read word.
- The top-level block holds the FSM, counter, storage, and response registers.

Test Plan:
- LATENCY = 3: SW 0xDEADBEEF to addr 0x10, then LW from 0x10 → resp_valid exactly 3 cycles after each accept; rdata 0xDEADBEEF; err 0.
- SB 0x7F to 0x11 after the above, then LW from 0x10 → 0xDEAD7FEF. LB from 0x13 → 0xFFFFFFDE. LBU from 0x13 → 0x000000DE.
- SH 0x8001 to 0x12, then LH from 0x12 → 0xFFFF8001; LHU from 0x12 → 0x00008001.
- Hold resp_ready = 0 for 5 cycles → resp_valid and rdata stable, req_ready = 0, and a concurrent req_valid is not accepted.
- Pulse rst_n low while in WAIT → next edge resp_valid = 0, req_ready = 1 after release, and no stale response appears.
- With DMEM_MISALIGN_TRAP_EN: LW from 0x12 → err = 1, rdata = 0. SW to 0x12 → err = 1 and memory is unchanged (checked by LW from 0x10).
- Without DMEM_MISALIGN_TRAP_EN: LW from 0x12 → reads word 0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_hs data memory.
// Holds load/store funct3 encodings, the handshake FSM state type, the access
// size type, and helpers that decode size, lane alignment and misalignment.
package dmem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LAT_CNT_W = 4;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Access size from direction and funct3; undefined encodings behave as word.
  function automatic size_t access_size(input logic we, input logic [2:0] ftype);
    size_t sz;
    sz = SZ_W;
    if (we) begin
      case (ftype)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        F3_SW:   sz = SZ_W;
        default: sz = SZ_W;
      endcase
    end else begin
      case (ftype)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        F3_LW:         sz = SZ_W;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  // Halfwords need an even lane, words need lane 0.
  function automatic logic misaligned(input size_t size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_H:    mis = lane[0];
      SZ_W:    mis = (lane != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Lane actually used: low address bits that the size cannot honour are dropped.
  function automatic logic [1:0] aligned_lane(input size_t size, input logic [1:0] lane);
    logic [1:0] al;
    case (size)
      SZ_B:    al = lane;
      SZ_H:    al = {lane[1], 1'b0};
      default: al = 2'b00;
    endcase
    return al;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for dmem_hs (purely combinational).
// Ports:
//   we       1  store (1) / load (0), selects funct3 decoding
//   ftype    3  funct3 of the access
//   lane     2  byte address bits [1:0]
//   wdata   32  right-justified store data
//   rword   32  storage word at the addressed index
//   be_c     4  byte enables for the store
//   wword_c 32  store data replicated onto every lane it may land in
//   rdata_c 32  load value extracted from rword and sign/zero extended
module dmem_lane
  import dmem_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        ftype,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        be_c,
  output logic [WORD_W-1:0] wword_c,
  output logic [WORD_W-1:0] rdata_c
);

  size_t             size_c;
  logic [1:0]        eff_lane_c;
  logic              is_unsigned_c;
  logic [WORD_W-1:0] shifted_c;

  // Replicating the store data means the byte enables alone pick the lane.
  always_comb begin
    size_c        = access_size(we, ftype);
    eff_lane_c    = aligned_lane(size_c, lane);
    is_unsigned_c = (ftype == F3_LBU) || (ftype == F3_LHU);
    shifted_c     = rword >> {eff_lane_c, 3'b000};
    be_c          = 4'b1111;
    wword_c       = wdata;
    rdata_c       = rword;
    case (size_c)
      SZ_B: begin
        be_c    = 4'b0001 << eff_lane_c;
        wword_c = {4{wdata[7:0]}};
        rdata_c = is_unsigned_c ? {24'h0, shifted_c[7:0]}
                                : {{24{shifted_c[7]}}, shifted_c[7:0]};
      end
      SZ_H: begin
        be_c    = 4'b0011 << eff_lane_c;
        wword_c = {2{wdata[15:0]}};
        rdata_c = is_unsigned_c ? {16'h0, shifted_c[15:0]}
                                : {{16{shifted_c[15]}}, shifted_c[15:0]};
      end
      default: begin
        be_c    = 4'b1111;
        wword_c = wdata;
        rdata_c = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// Byte-addressed, word-organised data memory with valid/ready request and
// response handshakes and a configurable read latency (one transaction in
// flight). Stores commit on the accept edge; loads are captured on the accept
// edge and presented LATENCY cycles later.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses return resp_err=1 with zero data and never write storage;
// when undefined they are force-aligned and resp_err stays 0.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid / req_ready  request handshake
//   req_we                 1 = store, 0 = load
//   req_addr   ADDR_W      byte address
//   req_wdata  32          right-justified store data
//   req_type   3           funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   resp_valid/resp_ready  response handshake
//   resp_rdata 32          extended load data, 0 for stores and errors
//   resp_err   1           misaligned access fault
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int unsigned    DEPTH     = 32768,
  parameter int unsigned    LATENCY   = 1,
  parameter string          INIT_FILE = "",
  localparam int unsigned   ADDR_W    = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [2:0]        req_type,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD =
    (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

  logic [WORD_W-1:0]    mem [DEPTH];
  state_t               state;
  logic [LAT_CNT_W-1:0] cnt;

  logic                 accept_c;
  logic                 err_c;
  logic                 wr_en_c;
  logic [IDX_W-1:0]     widx_c;
  logic [1:0]           lane_c;
  logic [3:0]           be_c;
  logic [WORD_W-1:0]    wword_c;
  logic [WORD_W-1:0]    rword_c;
  logic [WORD_W-1:0]    rval_c;

  assign req_ready = (state == ST_IDLE) && rst_n;
  assign accept_c  = req_valid && req_ready;
  assign widx_c    = req_addr[ADDR_W-1:2];
  assign lane_c    = req_addr[1:0];
  assign rword_c   = mem[widx_c];

`ifdef DMEM_MISALIGN_TRAP_EN
  size_t size_c;
  assign size_c = access_size(req_we, req_type);
  assign err_c  = misaligned(size_c, lane_c);
`else
  assign err_c  = 1'b0;
`endif

  assign wr_en_c = accept_c && req_we && !err_c;

  dmem_lane u_lane (
    .we      (req_we),
    .ftype   (req_type),
    .lane    (lane_c),
    .wdata   (req_wdata),
    .rword   (rword_c),
    .be_c    (be_c),
    .wword_c (wword_c),
    .rdata_c (rval_c)
  );

  // Byte-masked store commit; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem[widx_c][8*b +: 8] <= wword_c[8*b +: 8];
        end
      end
    end
  end

  // Handshake FSM with latency counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            resp_err   <= err_c;
            resp_rdata <= (req_we || err_c) ? '0 : rval_c;
            if (LATENCY == 1) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - LAT_CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: directed steps followed by randomized
// accesses, compared against a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_hs;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;
  localparam int unsigned AW    = $clog2(DEPTH) + 2;
  localparam int unsigned TOP_A = DEPTH * 4 - 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_type;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_type   (req_type),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: size from funct3, align or trap, then byte-array read/write.
  function automatic void model(input logic we, input logic [2:0] t, input int unsigned a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned sz;
    int unsigned base;
    longint unsigned v;
    if (we) sz = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
    else    sz = (t == 3'd0 || t == 3'd4) ? 1 : (t == 3'd1 || t == 3'd5) ? 2 : 4;
    rd = 32'h0;
    er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % sz) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = a - (a % sz);
    if (we) begin
      for (int k = 0; k < int'(sz); k++) ref_mem[base + k] = 8'(wd >> (8 * k));
    end else begin
      v = 0;
      for (int k = 0; k < int'(sz); k++) v = v + (longint'(ref_mem[base + k]) << (8 * k));
      if ((t == 3'd0 || t == 3'd1) && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
        v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
      rd = 32'(v);
    end
  endfunction

  // Drive request fields that must be ignored while the block is busy.
  task automatic junk();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_type  = 3'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  // One transaction: accept, latency count, optional backpressure hold, handshake.
  task automatic xact(input logic we, input logic [2:0] t, input logic [AW-1:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] rd0;
    logic er0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    resp_ready = 1'($urandom);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    junk();
    lat = 1;
    while (!resp_valid && lat < 40) begin
      resp_ready = 1'($urandom);
      @(negedge clk);
      junk();
      lat++;
    end
    check("resp_valid_rise", 32'(resp_valid), 32'd1);
    rd0 = resp_rdata;
    er0 = resp_err;
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_type = 3'd2; req_addr = AW'(32'h10);
      req_wdata = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, rd0);
      check("hold_err", 32'(resp_err), 32'(er0));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
    check("req_ready_after_resp", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] t, input int unsigned a,
                     input logic [31:0] wd, input int hold, output logic [31:0] rd);
    logic [31:0] erd;
    logic eer;
    logic er;
    int lat;
    model(we, t, a, wd, erd, eer);
    xact(we, t, AW'(a), wd, hold, rd, er, lat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 32'(er), 32'(eer));
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic eer;
    int unsigned a;
    int w;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_type = '0; resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("post_rst_rdata", resp_rdata, 32'h0);
    check("post_rst_err", 32'(resp_err), 32'd0);

    // Directed byte-lane placement
    run("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd);
    run("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
    check("lw_10_const", rd, 32'hDEADBEEF);
    run("sb_11", 1'b1, 3'd0, 32'h11, 32'h0000007F, 0, rd);
    run("lw_10b", 1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
    check("lw_10b_const", rd, 32'hDEAD7FEF);
    run("lb_13", 1'b0, 3'd0, 32'h13, 32'h0, 0, rd);
    check("lb_13_const", rd, 32'hFFFFFFDE);
    run("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 0, rd);
    check("lbu_13_const", rd, 32'h000000DE);
    run("sh_12", 1'b1, 3'd1, 32'h12, 32'h00008001, 0, rd);
    run("lh_12", 1'b0, 3'd1, 32'h12, 32'h0, 0, rd);
    check("lh_12_const", rd, 32'hFFFF8001);
    run("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0, 0, rd);
    check("lhu_12_const", rd, 32'h00008001);

    // Backpressure: 5 cycles with resp_ready low and store attempts that must be ignored
    run("hold_lw", 1'b0, 3'd2, 32'h10, 32'h0, 5, rd);
    run("lw_after_hold", 1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
    check("lw_after_hold_const", rd, 32'h80017FEF);

    // Misaligned accesses
    run("lw_12", 1'b0, 3'd2, 32'h12, 32'h0, 0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw_12_trap_const", rd, 32'h0);
`else
    check("lw_12_align_const", rd, 32'h80017FEF);
`endif
    run("sw_12", 1'b1, 3'd2, 32'h12, 32'h11111111, 0, rd);
    run("lw_10_after_sw12", 1'b0, 3'd2, 32'h10, 32'h0, 0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sw_12_trap_unchanged", rd, 32'h80017FEF);
`else
    check("sw_12_aligned_write", rd, 32'h11111111);
`endif

    // Highest valid word
    run("sw_top", 1'b1, 3'd2, TOP_A, 32'hA5C3_0F96, 0, rd);
    run("lw_top", 1'b0, 3'd2, TOP_A, 32'h0, 0, rd);
    check("lw_top_const", rd, 32'hA5C30F96);

    // Reset while in WAIT: committed store stays, response is dropped
    model(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'd2; req_addr = AW'(32'h20);
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("wait_rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("wait_rel_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      resp_ready = 1'($urandom);
      @(negedge clk);
      check("no_stale_resp", 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    run("lw_20", 1'b0, 3'd2, 32'h20, 32'h0, 0, rd);
    check("lw_20_const", rd, 32'hCAFEF00D);

    // Randomized accesses over an initialised region plus the top word
    for (int i = 0; i < 16; i++) run("init", 1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd);
    for (int i = 0; i < 60; i++) begin
      w = int'($urandom_range(0, 16));
      a = (w == 16) ? TOP_A : 32'(w * 4);
      a = a + $urandom_range(0, 3);
      run("rnd", 1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
